// File: rtl/dac_serial_tx.sv
// Serial transmitter for a 16-bit-frame DAC: 4 control bits followed by a
// 12-bit sample, MSB first. Each frame is framed by an active-low chip select
// and followed by an active-low ldac pulse that loads the DAC output.
module dac_serial_tx #(
  parameter logic [3:0] CTRL_BITS  = 4'b0000,
  parameter int         LDAC_WIDTH = 2
) (
  input  logic        dacSerialClock,
  input  logic        reset,
  input  logic [11:0] sampleIn,
  input  logic        sampleValid,
  input  logic        syncDAC,
  output logic        dacDataIn,
  output logic        dacCsN,
  output logic        ldac,
  output logic        busy,
  output logic        syncMissed
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_t;

  localparam logic [2:0] LDAC_W3 = 3'(LDAC_WIDTH);

  state_t      r_state;
  logic [11:0] r_holding;
  logic [15:0] r_shift;
  logic [3:0]  r_bit_cnt;
  logic [2:0]  r_ldac_cnt;
  logic        r_data;
  logic        r_cs_n;
  logic        r_ldac;
  logic        r_busy;
  logic        r_missed;

  state_t      w_state_nxt;
  logic [11:0] w_holding_nxt;
  logic [15:0] w_shift_nxt;
  logic [3:0]  w_bit_cnt_nxt;
  logic [2:0]  w_ldac_cnt_nxt;
  logic        w_data_nxt;
  logic        w_cs_n_nxt;
  logic        w_ldac_nxt;
  logic        w_busy_nxt;
  logic        w_missed_nxt;

  logic [11:0] w_sample;
  logic [15:0] w_frame;
  logic        w_ldac_done;
  logic        w_start;

  // A sample strobed on the same edge as the frame start wins over the old holding value.
  assign w_sample    = sampleValid ? sampleIn : r_holding;
  assign w_frame     = {CTRL_BITS, w_sample};
  assign w_ldac_done = (r_state == LOAD) && (r_ldac_cnt == LDAC_W3);
  // The last ldac cycle doubles as an idle slot, so a frame period of
  // 16+LDAC_WIDTH cycles is sustainable without a missed sync.
  assign w_start     = syncDAC && ((r_state == IDLE) || w_ldac_done);

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    w_state_nxt    = r_state;
    w_holding_nxt  = sampleValid ? sampleIn : r_holding;
    w_shift_nxt    = r_shift;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_ldac_cnt_nxt = r_ldac_cnt;
    w_data_nxt     = r_data;
    w_cs_n_nxt     = r_cs_n;
    w_ldac_nxt     = r_ldac;
    w_busy_nxt     = r_busy;
    w_missed_nxt   = r_missed;

    if (w_start) begin
      // Bit 15 goes straight to the pin; the rest waits in the shift register.
      w_state_nxt    = SHIFT;
      w_shift_nxt    = {w_frame[14:0], 1'b0};
      w_data_nxt     = w_frame[15];
      w_bit_cnt_nxt  = 4'd0;
      w_ldac_cnt_nxt = 3'd0;
      w_cs_n_nxt     = 1'b0;
      w_ldac_nxt     = 1'b1;
      w_busy_nxt     = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          w_cs_n_nxt = 1'b1;
          w_data_nxt = 1'b0;
          w_ldac_nxt = 1'b1;
          w_busy_nxt = 1'b0;
        end
        SHIFT: begin
          if (syncDAC) begin
            w_missed_nxt = 1'b1;
          end else begin
            w_missed_nxt = r_missed;
          end
          if (r_bit_cnt == 4'd15) begin
            w_state_nxt    = LOAD;
            w_cs_n_nxt     = 1'b0 | 1'b1;
            w_data_nxt     = 1'b0;
            w_ldac_nxt     = 1'b0;
            w_ldac_cnt_nxt = 3'd1;
            w_bit_cnt_nxt  = 4'd0;
            w_shift_nxt    = 16'h0000;
          end else begin
            w_data_nxt    = r_shift[15];
            w_shift_nxt   = {r_shift[14:0], 1'b0};
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          end
        end
        LOAD: begin
          if (w_ldac_done) begin
            w_state_nxt    = IDLE;
            w_ldac_nxt     = 1'b1;
            w_busy_nxt     = 1'b0;
            w_ldac_cnt_nxt = 3'd0;
          end else begin
            w_ldac_cnt_nxt = r_ldac_cnt + 3'd1;
            if (syncDAC) begin
              w_missed_nxt = 1'b1;
            end else begin
              w_missed_nxt = r_missed;
            end
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cs_n_nxt  = 1'b1;
          w_data_nxt  = 1'b0;
          w_ldac_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; reset aborts any frame without an ldac pulse.
  always_ff @(posedge dacSerialClock or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_holding  <= 12'h000;
      r_shift    <= 16'h0000;
      r_bit_cnt  <= 4'd0;
      r_ldac_cnt <= 3'd0;
      r_data     <= 1'b0;
      r_cs_n     <= 1'b1;
      r_ldac     <= 1'b1;
      r_busy     <= 1'b0;
      r_missed   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_holding  <= w_holding_nxt;
      r_shift    <= w_shift_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_ldac_cnt <= w_ldac_cnt_nxt;
      r_data     <= w_data_nxt;
      r_cs_n     <= w_cs_n_nxt;
      r_ldac     <= w_ldac_nxt;
      r_busy     <= w_busy_nxt;
      r_missed   <= w_missed_nxt;
    end
  end

  assign dacDataIn  = r_data;
  assign dacCsN     = r_cs_n;
  assign ldac       = r_ldac;
  assign busy       = r_busy;
  assign syncMissed = r_missed;

endmodule

// File: tb/tb_dac_serial_tx.sv
// Directed bench for dac_serial_tx: a default instance plus one with
// CTRL_BITS=4'b0011 and LDAC_WIDTH=1, both driven by the same stimulus.
module tb_dac_serial_tx;

  logic        clk;
  logic        reset;
  logic [11:0] sampleIn;
  logic        sampleValid;
  logic        syncDAC;
  logic        dacDataIn, dacCsN, ldac, busy, syncMissed;
  logic        dacDataIn2, dacCsN2, ldac2, busy2, syncMissed2;

  int total;
  int bad;

  logic dt_a [0:39];
  logic cs_a [0:39];
  logic ld_a [0:39];
  logic by_a [0:39];
  logic dt2_a [0:39];
  logic cs2_a [0:39];
  logic ld2_a [0:39];
  logic by2_a [0:39];

  dac_serial_tx dut (
    .dacSerialClock(clk), .reset(reset), .sampleIn(sampleIn),
    .sampleValid(sampleValid), .syncDAC(syncDAC), .dacDataIn(dacDataIn),
    .dacCsN(dacCsN), .ldac(ldac), .busy(busy), .syncMissed(syncMissed)
  );

  dac_serial_tx #(.CTRL_BITS(4'b0011), .LDAC_WIDTH(1)) dut2 (
    .dacSerialClock(clk), .reset(reset), .sampleIn(sampleIn),
    .sampleValid(sampleValid), .syncDAC(syncDAC), .dacDataIn(dacDataIn2),
    .dacCsN(dacCsN2), .ldac(ldac2), .busy(busy2), .syncMissed(syncMissed2)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Records n samples starting now (1 unit after frame-start edge T);
  // optionally pulses syncDAC on edge T+sync_at.
  task automatic capture(input int n, input int sync_at);
    for (int i = 0; i < n; i++) begin
      dt_a[i] = dacDataIn;  cs_a[i] = dacCsN;  ld_a[i] = ldac;  by_a[i] = busy;
      dt2_a[i] = dacDataIn2; cs2_a[i] = dacCsN2; ld2_a[i] = ldac2; by2_a[i] = busy2;
      if (i < n - 1) begin
        syncDAC = (i == sync_at - 1);
        step();
      end
    end
    syncDAC = 1'b0;
  endtask

  function automatic logic [15:0] bits_of(input int dummy);
    logic [15:0] w;
    w = 16'h0000;
    for (int k = 0; k < 16; k++) w[15-k] = dt_a[k] ^ (dummy != 0);
    return w;
  endfunction

  function automatic logic [15:0] bits2_of();
    logic [15:0] w;
    w = 16'h0000;
    for (int k = 0; k < 16; k++) w[15-k] = dt2_a[k];
    return w;
  endfunction

  function automatic int count_low(input int which, input int n);
    int c;
    c = 0;
    for (int i = 0; i < n; i++) begin
      case (which)
        0: if (cs_a[i] == 1'b0) c++;
        1: if (ld_a[i] == 1'b0) c++;
        2: if (ld2_a[i] == 1'b0) c++;
        default: c = c;
      endcase
    end
    return c;
  endfunction

  task automatic test_reset();
    reset = 1'b1; sampleValid = 1'b0; syncDAC = 1'b0; sampleIn = 12'h000;
    step(); step();
    total++;
    if ({dacCsN, ldac, dacDataIn, busy, syncMissed} !== 5'b11000) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=11000", {dacCsN, ldac, dacDataIn, busy, syncMissed});
    end
    reset = 1'b0;
    step(); step();
    total++;
    if ({dacCsN, ldac, dacDataIn, busy} !== 4'b1100) begin
      bad++;
      $display("FAIL idle_after_reset got=%b want=1100", {dacCsN, ldac, dacDataIn, busy});
    end
  endtask

  task automatic test_basic();
    int v;
    sampleValid = 1'b1; sampleIn = 12'hA5C;
    step();
    sampleValid = 1'b0; syncDAC = 1'b1;
    step();
    syncDAC = 1'b0;
    capture(25, -1);
    total++;
    if (bits_of(0) !== 16'h0A5C) begin
      bad++; $display("FAIL basic_bits got=%h want=0a5c", bits_of(0));
    end
    total++;
    if (count_low(0, 25) != 16 || cs_a[0] !== 1'b0 || cs_a[16] !== 1'b1) begin
      bad++; $display("FAIL basic_csn low=%0d cs16=%b want low=16 cs16=1", count_low(0, 25), cs_a[16]);
    end
    total++;
    if (count_low(1, 25) != 2 || ld_a[15] !== 1'b1 || ld_a[16] !== 1'b0 || ld_a[17] !== 1'b0) begin
      bad++; $display("FAIL basic_ldac low=%0d want=2 at cycles 16,17", count_low(1, 25));
    end
    total++;
    if (by_a[0] !== 1'b1 || by_a[17] !== 1'b1 || by_a[18] !== 1'b0) begin
      bad++; $display("FAIL basic_busy b0=%b b17=%b b18=%b want 1 1 0", by_a[0], by_a[17], by_a[18]);
    end
    v = 0;
    for (int i = 0; i < 25; i++) if (cs_a[i] === 1'b1 && dt_a[i] !== 1'b0) v++;
    total++;
    if (v != 0) begin
      bad++; $display("FAIL basic_data_idle got=%0d nonzero bits want=0", v);
    end
    total++;
    if (syncMissed !== 1'b0) begin
      bad++; $display("FAIL basic_missed got=%b want=0", syncMissed);
    end
  endtask

  task automatic test_simultaneous();
    sampleValid = 1'b1; sampleIn = 12'hFFF;
    step();
    sampleIn = 12'h123; syncDAC = 1'b1;
    step();
    sampleValid = 1'b0; syncDAC = 1'b0;
    capture(25, -1);
    total++;
    if (bits_of(0) !== 16'h0123) begin
      bad++; $display("FAIL simul_bits got=%h want=0123", bits_of(0));
    end
  endtask

  task automatic test_retransmit();
    step(); step();
    syncDAC = 1'b1;
    step();
    syncDAC = 1'b0;
    capture(25, -1);
    total++;
    if (bits_of(0) !== 16'h0123) begin
      bad++; $display("FAIL retransmit_bits got=%h want=0123", bits_of(0));
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] w0, w1, w2;
    logic        cs20;
    w0 = 16'h0000; w1 = 16'h0000; w2 = 16'h0000; cs20 = 1'b0;
    for (int c = 0; c < 60; c++) begin
      syncDAC = (c == 0 || c == 18 || c == 36);
      step();
      if (c < 16) w0[15-c] = dacDataIn;
      else if (c >= 18 && c < 34) w1[15-(c-18)] = dacDataIn;
      else if (c >= 36 && c < 52) w2[15-(c-36)] = dacDataIn;
    end
    syncDAC = 1'b0;
    total++;
    if (w0 !== 16'h0123 || w1 !== 16'h0123 || w2 !== 16'h0123) begin
      bad++; $display("FAIL b2b18_frames got=%h %h %h want=0123 each", w0, w1, w2);
    end
    total++;
    if (syncMissed !== 1'b0) begin
      bad++; $display("FAIL b2b18_missed got=%b want=0", syncMissed);
    end
    w0 = 16'h0000;
    for (int c = 0; c < 40; c++) begin
      syncDAC = (c == 0 || c == 17);
      step();
      if (c < 16) w0[15-c] = dacDataIn;
      if (c == 20) cs20 = dacCsN;
    end
    syncDAC = 1'b0;
    total++;
    if (w0 !== 16'h0123 || cs20 !== 1'b1) begin
      bad++; $display("FAIL b2b17_frame got=%h cs20=%b want=0123 cs20=1", w0, cs20);
    end
    total++;
    if (syncMissed !== 1'b1) begin
      bad++; $display("FAIL b2b17_missed got=%b want=1", syncMissed);
    end
  endtask

  task automatic test_overrun();
    reset = 1'b1;
    step();
    reset = 1'b0; sampleValid = 1'b1; sampleIn = 12'h3C3;
    step();
    sampleValid = 1'b0; syncDAC = 1'b1;
    step();
    syncDAC = 1'b0;
    capture(25, 5);
    total++;
    if (bits_of(0) !== 16'h03C3 || count_low(0, 25) != 16) begin
      bad++; $display("FAIL overrun_frame got=%h low=%0d want=03c3 low=16", bits_of(0), count_low(0, 25));
    end
    for (int i = 0; i < 10; i++) step();
    total++;
    if (syncMissed !== 1'b1) begin
      bad++; $display("FAIL overrun_sticky got=%b want=1", syncMissed);
    end
    reset = 1'b1;
    #1;
    total++;
    if (syncMissed !== 1'b0) begin
      bad++; $display("FAIL overrun_clear got=%b want=0", syncMissed);
    end
    step();
    reset = 1'b0;
  endtask

  task automatic test_midframe_reset();
    int ld_lo, cs_lo;
    sampleValid = 1'b1; sampleIn = 12'h5A5;
    step();
    sampleValid = 1'b0; syncDAC = 1'b1;
    step();
    syncDAC = 1'b0;
    for (int i = 0; i < 7; i++) step();
    reset = 1'b1;
    #1;
    total++;
    if ({dacCsN, dacDataIn, busy, ldac} !== 4'b1001) begin
      bad++; $display("FAIL midreset_immediate got=%b want=1001", {dacCsN, dacDataIn, busy, ldac});
    end
    step(); step();
    reset = 1'b0;
    ld_lo = 0; cs_lo = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (ldac === 1'b0) ld_lo++;
      if (dacCsN === 1'b0) cs_lo++;
    end
    total++;
    if (ld_lo != 0 || cs_lo != 0) begin
      bad++; $display("FAIL midreset_no_resume ldac_low=%0d cs_low=%0d want 0 0", ld_lo, cs_lo);
    end
    syncDAC = 1'b1;
    step();
    syncDAC = 1'b0;
    capture(25, -1);
    total++;
    if (bits_of(0) !== 16'h0000 || count_low(0, 25) != 16 || count_low(1, 25) != 2) begin
      bad++; $display("FAIL midreset_next_frame got=%h cs=%0d ld=%0d want=0000 16 2",
                      bits_of(0), count_low(0, 25), count_low(1, 25));
    end
  endtask

  task automatic test_params();
    reset = 1'b1;
    step();
    reset = 1'b0; sampleValid = 1'b1; sampleIn = 12'h800; syncDAC = 1'b1;
    step();
    sampleValid = 1'b0; syncDAC = 1'b0;
    capture(25, -1);
    total++;
    if (bits2_of() !== 16'h3800) begin
      bad++; $display("FAIL param_bits got=%h want=3800", bits2_of());
    end
    total++;
    if (count_low(2, 25) != 1 || ld2_a[16] !== 1'b0 || by2_a[16] !== 1'b1 || by2_a[17] !== 1'b0) begin
      bad++; $display("FAIL param_ldac low=%0d busy16=%b busy17=%b want 1 1 0",
                      count_low(2, 25), by2_a[16], by2_a[17]);
    end
    total++;
    if (bits_of(0) !== 16'h0800) begin
      bad++; $display("FAIL param_default_bits got=%h want=0800", bits_of(0));
    end
  endtask

  // Runs every scenario in order and reports the tally.
  initial begin
    total = 0; bad = 0;
    reset = 1'b1; sampleValid = 1'b0; syncDAC = 1'b0; sampleIn = 12'h000;
    test_reset();
    test_basic();
    test_simultaneous();
    test_retransmit();
    test_back_to_back();
    test_overrun();
    test_midframe_reset();
    test_params();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
